// File: rtl/sgdlr_dot_accum.sv
// rtl/sgdlr_dot_accum.sv - signed product dot-product accumulator with rescale and valid/ready result
// Optional saturation of the narrowed result: define SGDLR_DOT_ACCUM_SAT_EN.
module sgdlr_dot_accum #(
  parameter int PROD_W     = 44,
  parameter int ACC_W      = 54,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 12,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              ovf,
  output logic              busy
);

  localparam int S_W = ACC_W - FRAC_SHIFT;

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic [ACC_W-1:0]   prod_ext;
  logic [S_W-1:0]     s;
  logic [OUT_W-1:0]   narrow_data;
  logic               narrow_ovf;
  logic               beat;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign beat     = in_valid && in_ready;
  assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};

  // Dropping the low FRAC_SHIFT bits of a two's-complement value is a floor shift.
  assign s = acc[ACC_W-1:FRAC_SHIFT];

`ifdef SGDLR_DOT_ACCUM_SAT_EN
  logic [S_W-OUT_W:0] upper;
  assign upper = s[S_W-1:OUT_W-1];

  always_comb begin
    narrow_ovf  = !((upper == '0) || (upper == '1));
    narrow_data = s[OUT_W-1:0];
    if (narrow_ovf)
      narrow_data = s[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign narrow_data = s[OUT_W-1:0];
  assign narrow_ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= vec_len;
            state <= (vec_len == '0) ? ROUND : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= acc + prod_ext;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1))
              state <= ROUND;
          end
        end
        ROUND: begin
          out_data  <= narrow_data;
          ovf       <= narrow_ovf;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdlr_dot_accum.sv
// tb/tb_sgdlr_dot_accum.sv - directed self-checking bench for sgdlr_dot_accum
module tb_sgdlr_dot_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] vec_len;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sgdlr_dot_accum dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [15:0] len);
    start   = 1'b1;
    vec_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [43:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // After the last accepted beat: ROUND for one cycle, then result presented.
  task automatic expect_result(input string tag, input logic [31:0] d, input logic o);
    check({tag, "_round_valid"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_ovf"}, ovf, o);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Basic: (4096+8192+12288+16384) >>> 12 = 10
    start_vec(16'd4);
    check("basic_busy", busy, 1'b1);
    beat("b1", 44'd4096); beat("b2", 44'd8192); beat("b3", 44'd12288); beat("b4", 44'd16384);
    expect_result("basic", 32'd10, 1'b0);
    tick();
    check("basic_valid_drop", out_valid, 1'b0);
    check("basic_idle", busy, 1'b0);
    check("basic_data_keep", out_data, 32'd10);

    // Backpressure plus spurious starts in ACCUM and HOLD
    out_ready = 1'b0;
    start_vec(16'd4);
    beat("p1", 44'd4096); beat("p2", 44'd8192);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1); vec_len = 16'd1;
      tick();
      check("bp_gap_busy", busy, 1'b1);
      check("bp_gap_ready", in_ready, 1'b1);
    end
    start = 1'b0;
    beat("p3", 44'd12288); beat("p4", 44'd16384);
    expect_result("bp", 32'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 32'd10);
      check("bp_hold_busy", busy, 1'b1);
    end
    // start coincident with the handshake must be dropped
    out_ready = 1'b1; start = 1'b1; vec_len = 16'd1;
    tick();
    start = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_hs_start_ignored", busy, 1'b0);

    // Negative floor: -12289 >>> 12 = -4
    start_vec(16'd1);
    beat("n1", -44'sd12289);
    expect_result("neg", 32'hFFFF_FFFC, 1'b0);
    tick();

    // Zero-length vector
    start_vec(16'd0);
    check("zero_busy", busy, 1'b1);
    check("zero_no_ready", in_ready, 1'b0);
    expect_result("zero", 32'd0, 1'b0);
    tick();

    // Overflow: 2*(2^43-1) >>> 12 = 2^32-1
    start_vec(16'd2);
    beat("o1", 44'h7FF_FFFF_FFFF); beat("o2", 44'h7FF_FFFF_FFFF);
`ifdef SGDLR_DOT_ACCUM_SAT_EN
    expect_result("ovf", 32'h7FFF_FFFF, 1'b1);
`else
    expect_result("ovf", 32'hFFFF_FFFF, 1'b0);
`endif
    tick();

    // Reset mid-ACCUM discards the partial sum
    start_vec(16'd4);
    beat("r1", 44'd4096); beat("r2", 44'd4096);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    start_vec(16'd1);
    beat("r3", 44'd4096);
    expect_result("post_rst", 32'd1, 1'b0);
    tick();
    check("end_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
